// File: rtl/acc_chain_pkg.sv
// Shared definitions for the cascaded accumulator controller.
// Holds the FSM state encoding and the default widths used by
// acc_chain_if, acc_chain_dp and acc_chain_ctrl.
package acc_chain_pkg;

    // Default burst-length field width; len == 0 encodes 2^LEN_W samples
    localparam int unsigned LEN_W_DEF = 4;
    // Default accumulator width
    localparam int unsigned DW_DEF    = 8;
    // Fixed sample width on the input stream
    localparam int unsigned IN_W      = 4;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : acc_chain_pkg

// File: rtl/acc_chain_if.sv
// Handshake/bus bundle of acc_chain_ctrl.
// Groups burst control (start/len/abort/busy), the sample stream
// (in_valid/in_data/in_ready) and the result channel
// (res_valid/res_ready/res_acc1..3/ovf).
//   slave  : seen from the controller
//   master : seen from the block driving bursts and taking results
interface acc_chain_if
    import acc_chain_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEF,
    parameter int unsigned DW    = DW_DEF
);

    logic              start;
    logic [LEN_W-1:0]  len;
    logic              abort;
    logic              busy;

    logic              in_valid;
    logic [IN_W-1:0]   in_data;
    logic              in_ready;

    logic              res_valid;
    logic              res_ready;
    logic [DW-1:0]     res_acc1;
    logic [DW-1:0]     res_acc2;
    logic [DW-1:0]     res_acc3;
    logic              ovf;

    modport slave (
        input  start, len, abort, in_valid, in_data, res_ready,
        output busy, in_ready, res_valid, res_acc1, res_acc2, res_acc3, ovf
    );

    modport master (
        output start, len, abort, in_valid, in_data, res_ready,
        input  busy, in_ready, res_valid, res_acc1, res_acc2, res_acc3, ovf
    );

endinterface : acc_chain_if

// File: rtl/acc_chain_dp.sv
// Datapath of acc_chain_ctrl: three cascaded accumulators with a sticky
// overflow flag.
//   acc1' = acc1 + data
//   acc2' = acc2 + acc1'
//   acc3' = acc3 + acc1' + acc2'
// Sums are formed at DW+2 bits; any carry beyond DW bits sets the flag.
// Build option ACC_CHAIN_SAT_EN: clamp each update to 2^DW-1 on
// overflow; otherwise updates wrap modulo 2^DW.
// Ports:
//   clk, reset       clock, synchronous active-low reset
//   acc_clr_i        zero the three accumulators (wins over en_i)
//   ovf_clr_i        clear the overflow flag
//   en_i             apply one sample
//   data_i           unsigned sample
//   acc1_o..acc3_o   accumulator registers
//   ovf_o            sticky overflow flag
module acc_chain_dp
    import acc_chain_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            acc_clr_i,
    input  logic            ovf_clr_i,
    input  logic            en_i,
    input  logic [IN_W-1:0] data_i,
    output logic [DW-1:0]   acc1_o,
    output logic [DW-1:0]   acc2_o,
    output logic [DW-1:0]   acc3_o,
    output logic            ovf_o
);

    localparam int unsigned SW = DW + 2;

    logic [DW-1:0] acc1_q, acc1_d;
    logic [DW-1:0] acc2_q, acc2_d;
    logic [DW-1:0] acc3_q, acc3_d;
    logic          ovf_q,  ovf_d;

    logic [SW-1:0] sum1, sum2, sum3;
    logic          carry1, carry2, carry3;
    logic [DW-1:0] acc1_n, acc2_n, acc3_n;

    // Cascaded adders; later stages see the already-fitted earlier results
    always_comb begin
        sum1   = SW'(acc1_q) + SW'(data_i);
        carry1 = |sum1[SW-1:DW];
`ifdef ACC_CHAIN_SAT_EN
        acc1_n = carry1 ? {DW{1'b1}} : sum1[DW-1:0];
`else
        acc1_n = sum1[DW-1:0];
`endif

        sum2   = SW'(acc2_q) + SW'(acc1_n);
        carry2 = |sum2[SW-1:DW];
`ifdef ACC_CHAIN_SAT_EN
        acc2_n = carry2 ? {DW{1'b1}} : sum2[DW-1:0];
`else
        acc2_n = sum2[DW-1:0];
`endif

        sum3   = SW'(acc3_q) + SW'(acc1_n) + SW'(acc2_n);
        carry3 = |sum3[SW-1:DW];
`ifdef ACC_CHAIN_SAT_EN
        acc3_n = carry3 ? {DW{1'b1}} : sum3[DW-1:0];
`else
        acc3_n = sum3[DW-1:0];
`endif
    end

    // Register update selection; clear beats enable
    always_comb begin
        acc1_d = acc1_q;
        acc2_d = acc2_q;
        acc3_d = acc3_q;
        ovf_d  = ovf_q;

        if (acc_clr_i) begin
            acc1_d = '0;
            acc2_d = '0;
            acc3_d = '0;
        end else if (en_i) begin
            acc1_d = acc1_n;
            acc2_d = acc2_n;
            acc3_d = acc3_n;
            ovf_d  = ovf_q | carry1 | carry2 | carry3;
        end

        if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc1_q <= '0;
            acc2_q <= '0;
            acc3_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            acc1_q <= acc1_d;
            acc2_q <= acc2_d;
            acc3_q <= acc3_d;
            ovf_q  <= ovf_d;
        end
    end

    assign acc1_o = acc1_q;
    assign acc2_o = acc2_q;
    assign acc3_o = acc3_q;
    assign ovf_o  = ovf_q;

endmodule : acc_chain_dp

// File: rtl/acc_chain_ctrl.sv
// Burst controller for the cascaded accumulator.
// A start in IDLE captures the burst length and clears the datapath;
// RUN accepts samples until the count is exhausted, then DONE presents
// the result until it is taken. abort in RUN drops the burst.
// Build option ACC_CHAIN_SAT_EN selects saturating accumulators
// (see acc_chain_dp); default is wrapping.
// Ports:
//   clk    clock, all state on rising edge
//   reset  synchronous active-low reset
//   bus    acc_chain_if.slave: start/len/abort/busy, in_valid/in_data/
//          in_ready, res_valid/res_ready/res_acc1..3/ovf
module acc_chain_ctrl
    import acc_chain_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEF,
    parameter int unsigned DW    = DW_DEF
) (
    input  logic        clk,
    input  logic        reset,
    acc_chain_if.slave  bus
);

    state_e           state_q, state_d;
    // Samples still to accept; 0 at capture means 2^LEN_W, the wrap on
    // decrement takes care of it since completion is detected at 1
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             busy_q;
    logic             in_ready_q;
    logic             res_valid_q;

    logic             acc_clr;
    logic             ovf_clr;
    logic             acc_en;
    logic             accept;

    logic [DW-1:0]    acc1, acc2, acc3;
    logic             ovf;

    assign accept = (state_q == RUN) && bus.in_valid;

    // Next-state, counter and datapath control
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        acc_clr = 1'b0;
        ovf_clr = 1'b0;
        acc_en  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rem_d   = bus.len;
                    acc_clr = 1'b1;
                    ovf_clr = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // abort outranks a coincident accept, including the last one
                if (bus.abort) begin
                    acc_clr = 1'b1;
                    state_d = IDLE;
                end else if (accept) begin
                    acc_en = 1'b1;
                    rem_d  = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and decoded status flops
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            busy_q      <= (state_d != IDLE);
            in_ready_q  <= (state_d == RUN);
            res_valid_q <= (state_d == DONE);
        end
    end

    acc_chain_dp #(
        .DW (DW)
    ) u_dp (
        .clk       (clk),
        .reset     (reset),
        .acc_clr_i (acc_clr),
        .ovf_clr_i (ovf_clr),
        .en_i      (acc_en),
        .data_i    (bus.in_data),
        .acc1_o    (acc1),
        .acc2_o    (acc2),
        .acc3_o    (acc3),
        .ovf_o     (ovf)
    );

    assign bus.busy      = busy_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_acc1  = acc1;
    assign bus.res_acc2  = acc2;
    assign bus.res_acc3  = acc3;
    assign bus.ovf       = ovf;

endmodule : acc_chain_ctrl

// File: tb/tb_acc_chain_ctrl.sv
// Self-checking bench for acc_chain_ctrl: a reference model computes the
// expected accumulators as samples are driven, results are queued and
// compared when the controller presents them.
module tb_acc_chain_ctrl;
    import acc_chain_pkg::*;

    localparam int unsigned LEN_W = 4;
    localparam int unsigned DW    = 8;
    localparam int          MAXV  = (1 << DW) - 1;

    typedef struct {
        int a1;
        int a2;
        int a3;
        int ovf;
    } res_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    acc_chain_if #(.LEN_W(LEN_W), .DW(DW)) bus ();

    acc_chain_ctrl #(.LEN_W(LEN_W), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    res_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   m1, m2, m3, movf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: fit one accumulator value into DW bits, noting overflow
    task automatic fit(inout int v);
        if (v > MAXV) begin
            movf = 1;
`ifdef ACC_CHAIN_SAT_EN
            v = MAXV;
`else
            v = v % (MAXV + 1);
`endif
        end
    endtask

    task automatic model_step(input int d);
        m1 = m1 + d;
        fit(m1);
        m2 = m2 + m1;
        fit(m2);
        m3 = m3 + m1 + m2;
        fit(m3);
    endtask

    task automatic start_burst(input int len_code);
        bus.start = 1'b1;
        bus.len   = LEN_W'(len_code);
        tick();
        bus.start = 1'b0;
        m1 = 0; m2 = 0; m3 = 0; movf = 0;
        chk("busy_after_start", 32'(bus.busy), 1);
        chk("acc1_cleared", 32'(bus.res_acc1), 0);
        chk("ovf_cleared", 32'(bus.ovf), 0);
    endtask

    task automatic feed(input int d, input int gap, input bit ab);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'(d);
        bus.abort    = ab;
        chk("in_ready", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        bus.abort    = 1'b0;
        if (!ab) model_step(d);
        repeat (gap) begin
            chk("no_early_result", 32'(bus.res_valid), 0);
            tick();
        end
    endtask

    // Called right after the final accept edge
    task automatic finish_burst();
        res_t e;
        chk("res_latency", 32'(bus.res_valid), 1);
        e.a1 = m1; e.a2 = m2; e.a3 = m3; e.ovf = movf;
        exp_q.push_back(e);
    endtask

    task automatic collect(input int hold, input bit poke_start);
        int          n;
        logic [31:0] snap;
        res_t        e;
        n = 0;
        while (!bus.res_valid && n < 50) begin
            tick();
            n++;
        end
        if (!bus.res_valid) begin
            chk("res_timeout", 0, 1);
            return;
        end
        snap = 32'({bus.res_acc1, bus.res_acc2, bus.res_acc3, bus.ovf});
        for (int i = 0; i < hold; i++) begin
            bus.res_ready = 1'b0;
            bus.start     = poke_start;
            tick();
            chk("hold_valid", 32'(bus.res_valid), 1);
            chk("hold_stable", 32'({bus.res_acc1, bus.res_acc2, bus.res_acc3, bus.ovf}), snap);
        end
        bus.start     = poke_start;
        bus.res_ready = 1'b1;
        if (exp_q.size() == 0) begin
            chk("unexpected_result", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("acc1", 32'(bus.res_acc1), e.a1);
            chk("acc2", 32'(bus.res_acc2), e.a2);
            chk("acc3", 32'(bus.res_acc3), e.a3);
            chk("ovf", 32'(bus.ovf), e.ovf);
        end
        tick();
        bus.res_ready = 1'b0;
        bus.start     = 1'b0;
        chk("idle_after_ack", 32'(bus.busy), 0);
        chk("valid_drop", 32'(bus.res_valid), 0);
        tick();
        chk("start_in_done_ignored", 32'(bus.busy), 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 0);
        chk({tag, "_res_valid"}, 32'(bus.res_valid), 0);
        chk({tag, "_acc"}, 32'({bus.res_acc1, bus.res_acc2, bus.res_acc3}), 0);
        chk({tag, "_ovf"}, 32'(bus.ovf), 0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.abort     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.res_ready = 1'b0;

        // Reset state
        repeat (2) tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();

        // Basic burst, back-to-back samples
        start_burst(3);
        feed(1, 0, 0);
        feed(2, 0, 0);
        feed(3, 0, 0);
        finish_burst();
        chk("basic_acc3_const", 32'(bus.res_acc3), 25);
        collect(0, 0);

        // Gaps and result back-pressure, start poked during DONE
        start_burst(3);
        feed(1, 2, 0);
        feed(2, 2, 0);
        feed(3, 0, 0);
        finish_burst();
        collect(5, 1);

        // Overflow: 16 samples of 15
        start_burst(0);
        for (int i = 0; i < 16; i++) feed(15, 0, 0);
        finish_burst();
        chk("ovf_acc1_const", 32'(bus.res_acc1), 240);
        chk("ovf_flag_const", 32'(bus.ovf), 1);
`ifdef ACC_CHAIN_SAT_EN
        chk("ovf_acc2_const", 32'(bus.res_acc2), 255);
        chk("ovf_acc3_const", 32'(bus.res_acc3), 255);
`else
        chk("ovf_acc2_const", 32'(bus.res_acc2), 248);
`endif
        collect(1, 0);

        // Abort on second accept, then a fresh one-sample burst
        start_burst(4);
        feed(1, 0, 0);
        feed(2, 0, 1);
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_valid", 32'(bus.res_valid), 0);
        chk("abort_acc_clr", 32'({bus.res_acc1, bus.res_acc2, bus.res_acc3}), 0);
        tick();
        chk("abort_no_result", 32'(bus.res_valid), 0);
        start_burst(1);
        feed(5, 0, 0);
        finish_burst();
        chk("len1_acc3_const", 32'(bus.res_acc3), 10);
        collect(0, 0);

        // Abort coincident with final accept
        start_burst(2);
        feed(4, 0, 0);
        feed(4, 0, 1);
        chk("abort_last_busy", 32'(bus.busy), 0);
        for (int i = 0; i < 3; i++) begin
            chk("abort_last_no_result", 32'(bus.res_valid), 0);
            tick();
        end

        // Reset in the middle of a burst
        start_burst(4);
        feed(3, 0, 0);
        feed(3, 0, 0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_all_zero("midreset");
        start_burst(3);
        feed(1, 0, 0);
        feed(2, 0, 0);
        feed(3, 0, 0);
        finish_burst();
        collect(0, 0);

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

endmodule : tb_acc_chain_ctrl
